ysyx_2022040010_cache_arbiter: RTL

Arbitrates instruction-cache and data-cache miss traffic onto the single core memory port, sequencing one line-sized burst at a time. It sits between the two caches and the bus bridge. It produces `stallreq_for_cache`, which the pipeline stall controller turns into the stall pattern that freezes the pipeline while any refill or writeback is outstanding.

---
 rtl/ysyx_2022040010_cache_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ysyx_2022040010_cache_arbiter.sv
// rtl/ysyx_2022040010_cache_arbiter.sv - icache/dcache miss arbiter onto one burst memory port
module ysyx_2022040010_cache_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic [DATA_W-1:0] icache_rdata,
  output logic              icache_rvalid,
  output logic              icache_done,
  input  logic              dcache_req,
  input  logic              dcache_we,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] dcache_wdata,
  output logic              dcache_wnext,
  output logic [DATA_W-1:0] dcache_rdata,
  output logic              dcache_rvalid,
  output logic              dcache_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_len,
  input  logic              mem_gnt,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_bvalid,
  output logic              stallreq_for_cache
);

  localparam int CNT_W = $clog2(LINE_BEATS);

  typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_t;

  state_t              state;
  logic                owner;
  logic [ADDR_W-1:0]   addr;
  logic                we;
  logic [CNT_W-1:0]    cnt;

  logic last_beat;
  logic in_addr, in_rdata, in_wdata, in_wresp;
  logic i_rd, d_rd;

  assign last_beat = (cnt == CNT_W'(LINE_BEATS - 1));

  // Outputs are decoded from state and forced low while reset is asserted,
  // so a mid-burst reset silences the bus immediately.
  assign in_addr  = rst && (state == ADDR);
  assign in_rdata = rst && (state == RDATA);
  assign in_wdata = rst && (state == WDATA);
  assign in_wresp = rst && (state == WRESP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 1'b0;
      addr  <= '0;
      we    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dcache_req) begin
            owner <= 1'b1;
            addr  <= dcache_addr;
            we    <= dcache_we;
            state <= ADDR;
          end else if (icache_req) begin
            owner <= 1'b0;
            addr  <= icache_addr;
            we    <= 1'b0;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (mem_gnt) state <= we ? WDATA : RDATA;
        end
        RDATA: begin
          if (mem_rvalid) begin
            cnt <= cnt + CNT_W'(1);
            if (last_beat) state <= IDLE;
          end
        end
        WDATA: begin
          if (mem_wready) begin
            cnt <= cnt + CNT_W'(1);
            if (last_beat) state <= WRESP;
          end
        end
        WRESP: begin
          if (mem_bvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req    = in_addr;
  assign mem_we     = in_addr && we;
  assign mem_addr   = in_addr ? addr : '0;
  assign mem_len    = in_addr ? 8'(LINE_BEATS - 1) : 8'd0;

  assign mem_wvalid   = in_wdata;
  assign mem_wdata    = in_wdata ? dcache_wdata : '0;
  assign dcache_wnext = in_wdata && mem_wready;

  assign i_rd = in_rdata && !owner;
  assign d_rd = in_rdata && owner;

  assign icache_rvalid = i_rd && mem_rvalid;
  assign icache_rdata  = i_rd ? mem_rdata : '0;
  assign icache_done   = icache_rvalid && last_beat;

  assign dcache_rvalid = d_rd && mem_rvalid;
  assign dcache_rdata  = d_rd ? mem_rdata : '0;
  assign dcache_done   = (dcache_rvalid && last_beat) || (in_wresp && mem_bvalid);

  assign stallreq_for_cache = icache_req || dcache_req || (rst && (state != IDLE));

endmodule
